mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM pipeline-register outputs, performs loads and stores over a valid/ready data-memory port, and stalls the upstream pipeline while an access is outstanding. It also resolves the destination register and loads the MEM/WB pipeline register, inserting a bubble whenever it stalls.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_wb_reg.sv | 47 ++++
 rtl/mem_access_stage.sv | 137 +++++++++++++
 tb/tb_mem_access_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// default widths and the control pattern that a MEM/WB bubble carries.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: a valid/ready request channel and a valid-only read response.
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int DW = DATA_W
);
  logic          req_valid;
  logic          req_ready;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, we, addr, wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears every field; wb_data is the
// write-back mux result, registered alongside its operands.
module mem_wb_reg import mem_stage_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  wb_ctrl_t      ctrl_d,
  input  logic [RW-1:0] reg_addr_d,
  input  logic [DW-1:0] alu_result_d,
  input  logic [DW-1:0] mem_data_d,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg,
  output logic [RW-1:0] wb_reg_addr,
  output logic [DW-1:0] wb_alu_result,
  output logic [DW-1:0] wb_mem_data,
  output logic [DW-1:0] wb_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_addr   <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_data       <= '0;
    end else if (bubble) begin
      wb_reg_write  <= BUBBLE_CTRL.reg_write;
      wb_mem_to_reg <= BUBBLE_CTRL.mem_to_reg;
      wb_reg_addr   <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_data       <= '0;
    end else begin
      wb_reg_write  <= ctrl_d.reg_write;
      wb_mem_to_reg <= ctrl_d.mem_to_reg;
      wb_reg_addr   <= reg_addr_d;
      wb_alu_result <= alu_result_d;
      wb_mem_data   <= mem_data_d;
      wb_data       <= ctrl_d.mem_to_reg ? mem_data_d : alu_result_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs one load/store at a time over the data
// port, stalls upstream while it is in flight and feeds the MEM/WB register.
module mem_access_stage import mem_stage_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] rt_in,
  input  logic          reg_dst_in,
  input  logic [RW-1:0] reg_addr_i_in,
  input  logic [RW-1:0] reg_addr_r_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic          reg_write_in,
  input  logic          mem_to_reg_in,
  output logic          stall_out,
  mem_stage_if.master   dmem,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg,
  output logic [RW-1:0] wb_reg_addr,
  output logic [DW-1:0] wb_alu_result,
  output logic [DW-1:0] wb_mem_data,
  output logic [DW-1:0] wb_data,
  output logic          align_err
);

  state_t        state_q, state_d;
  logic [DW-1:0] addr_q, wdata_q, rdata_q;
  logic          we_q;
  wb_ctrl_t      ctrl_q;
  logic [RW-1:0] reg_addr_q;

  logic          mem_op, aligned, start, misalign;
  logic [RW-1:0] reg_addr_sel;
  logic          wb_bubble;
  wb_ctrl_t      wb_ctrl_d;
  logic [RW-1:0] wb_reg_addr_d;
  logic [DW-1:0] wb_alu_d, wb_mem_d;

  assign mem_op       = mem_read_in | mem_write_in;
  assign aligned      = (alu_result_in[1:0] == 2'b00);
  assign start        = (state_q == IDLE) && mem_op && aligned;
  assign misalign     = (state_q == IDLE) && mem_op && !aligned;
  assign reg_addr_sel = reg_dst_in ? reg_addr_r_in : reg_addr_i_in;

  // Valid is decoded from the state register so an async reset drops it at once.
  assign dmem.req_valid = (state_q == REQ);
  assign dmem.we        = we_q;
  assign dmem.addr      = addr_q;
  assign dmem.wdata     = wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      ctrl_q     <= BUBBLE_CTRL;
      reg_addr_q <= '0;
      align_err  <= 1'b0;
    end else begin
      align_err <= misalign;
      if (start) begin
        addr_q     <= alu_result_in;
        wdata_q    <= rt_in;
        we_q       <= mem_write_in & ~mem_read_in;
        ctrl_q     <= '{reg_write: reg_write_in, mem_to_reg: mem_to_reg_in};
        reg_addr_q <= reg_addr_sel;
        rdata_q    <= '0;
      end else if (state_q == WAIT && dmem.rsp_valid) begin
        rdata_q <= dmem.rsp_rdata;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    stall_out     = 1'b0;
    wb_bubble     = 1'b0;
    wb_ctrl_d     = '{reg_write: reg_write_in, mem_to_reg: mem_to_reg_in};
    wb_reg_addr_d = reg_addr_sel;
    wb_alu_d      = alu_result_in;
    wb_mem_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall_out = 1'b1;
          state_d   = REQ;
        end
        if (misalign) wb_bubble = 1'b1;
      end
      REQ: begin
        stall_out = 1'b1;
        if (dmem.req_ready) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_out = 1'b1;
        if (dmem.rsp_valid) state_d = DONE;
      end
      DONE: begin
        state_d       = IDLE;
        wb_ctrl_d     = ctrl_q;
        wb_reg_addr_d = reg_addr_q;
        wb_alu_d      = addr_q;
        wb_mem_d      = rdata_q;
      end
      default: state_d = IDLE;
    endcase
    if (stall_out) wb_bubble = 1'b1;
  end

  mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (wb_bubble),
    .ctrl_d       (wb_ctrl_d),
    .reg_addr_d   (wb_reg_addr_d),
    .alu_result_d (wb_alu_d),
    .mem_data_d   (wb_mem_d),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_addr  (wb_reg_addr),
    .wb_alu_result(wb_alu_result),
    .wb_mem_data  (wb_mem_data),
    .wb_data      (wb_data)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change 1 time unit after the
// rising edge, outputs are compared on the falling edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, rt_in;
  logic        reg_dst_in;
  logic [4:0]  reg_addr_i_in, reg_addr_r_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic        stall_out;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_alu_result, wb_mem_data, wb_data;
  logic        align_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_if #(.DW(32)) dmem ();

  mem_access_stage #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result_in(alu_result_in),
    .rt_in        (rt_in),
    .reg_dst_in   (reg_dst_in),
    .reg_addr_i_in(reg_addr_i_in),
    .reg_addr_r_in(reg_addr_r_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .reg_write_in (reg_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .stall_out    (stall_out),
    .dmem         (dmem),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_addr  (wb_reg_addr),
    .wb_alu_result(wb_alu_result),
    .wb_mem_data  (wb_mem_data),
    .wb_data      (wb_data),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_result_in = '0; rt_in = '0; reg_dst_in = 1'b0;
    reg_addr_i_in = '0; reg_addr_r_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_out); end
    n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr, dmem.wdata} !== 66'd0) begin n_fail++; $display("FAIL reset_dmem: valid=%0b we=%0b addr=%h wdata=%h want all 0", dmem.req_valid, dmem.we, dmem.addr, dmem.wdata); end
    n_checks++; if ({wb_reg_write, wb_mem_to_reg, wb_reg_addr, wb_alu_result, wb_mem_data, wb_data, align_err} !== 104'd0) begin n_fail++; $display("FAIL reset_wb: rw=%0b m2r=%0b ra=%0d alu=%h mem=%h data=%h aerr=%0b want all 0", wb_reg_write, wb_mem_to_reg, wb_reg_addr, wb_alu_result, wb_mem_data, wb_data, align_err); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    reg_write_in = 1'b1; reg_dst_in = 1'b1; reg_addr_r_in = 5'd5; reg_addr_i_in = 5'd7;
    alu_result_in = 32'h1234;
    @(negedge clk);
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %0b want 0", stall_out); end
    n_checks++; if (dmem.req_valid !== 1'b0) begin n_fail++; $display("FAIL alu_req_valid: got %0b want 0", dmem.req_valid); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (wb_reg_addr !== 5'd5) begin n_fail++; $display("FAIL alu_wb_reg_addr: got %0d want 5", wb_reg_addr); end
    n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_wb_data: got %h want 00001234", wb_data); end
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb_reg_write: got %0b want 1", wb_reg_write); end
    n_checks++; if (wb_mem_data !== 32'h0) begin n_fail++; $display("FAIL alu_wb_mem_data: got %h want 0", wb_mem_data); end
    tick();
  endtask

  task automatic test_load();
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
    reg_dst_in = 1'b0; reg_addr_i_in = 5'd9; alu_result_in = 32'h100;
    dmem.req_ready = 1'b1;
    @(negedge clk);  // N: IDLE
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL load_stall_n0: got %0b want 1", stall_out); end
    tick();
    @(negedge clk);  // N+1: REQ
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL load_stall_n1: got %0b want 1", stall_out); end
    n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr} !== {1'b1, 1'b0, 32'h100}) begin n_fail++; $display("FAIL load_req: valid=%0b we=%0b addr=%h want 1 0 00000100", dmem.req_valid, dmem.we, dmem.addr); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL load_bubble_n1: got %0b want 0", wb_reg_write); end
    tick();
    dmem.rsp_valid = 1'b1; dmem.rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);  // N+2: WAIT
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL load_stall_n2: got %0b want 1", stall_out); end
    n_checks++; if (dmem.req_valid !== 1'b0) begin n_fail++; $display("FAIL load_wait_valid: got %0b want 0", dmem.req_valid); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL load_bubble_n2: got %0b want 0", wb_reg_write); end
    tick();
    dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
    @(negedge clk);  // N+3: DONE
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL load_stall_n3: got %0b want 0", stall_out); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL load_bubble_n3: got %0b want 0", wb_reg_write); end
    tick();
    clear_inputs();
    @(negedge clk);  // N+4: MEM/WB valid
    n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wb_data: got %h want deadbeef", wb_data); end
    n_checks++; if ({wb_reg_write, wb_mem_to_reg, wb_reg_addr} !== {1'b1, 1'b1, 5'd9}) begin n_fail++; $display("FAIL load_wb_ctrl: rw=%0b m2r=%0b ra=%0d want 1 1 9", wb_reg_write, wb_mem_to_reg, wb_reg_addr); end
    n_checks++; if ({wb_alu_result, wb_mem_data} !== {32'h100, 32'hDEADBEEF}) begin n_fail++; $display("FAIL load_wb_fields: alu=%h mem=%h want 00000100 deadbeef", wb_alu_result, wb_mem_data); end
    tick();
  endtask

  task automatic test_store_backpressure();
    mem_write_in = 1'b1; alu_result_in = 32'h200; rt_in = 32'hCAFEF00D;
    reg_addr_i_in = 5'd3;
    dmem.req_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL store_stall_n0: got %0b want 1", stall_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr, dmem.wdata} !== {1'b1, 1'b1, 32'h200, 32'hCAFEF00D}) begin n_fail++; $display("FAIL store_hold_%0d: valid=%0b we=%0b addr=%h wdata=%h want 1 1 00000200 cafef00d", i, dmem.req_valid, dmem.we, dmem.addr, dmem.wdata); end
      n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL store_stall_hold_%0d: got %0b want 1", i, stall_out); end
      tick();
    end
    dmem.req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({dmem.req_valid, dmem.addr, dmem.wdata} !== {1'b1, 32'h200, 32'hCAFEF00D}) begin n_fail++; $display("FAIL store_handshake: valid=%0b addr=%h wdata=%h want 1 00000200 cafef00d", dmem.req_valid, dmem.addr, dmem.wdata); end
    tick();
    dmem.req_ready = 1'b0;
    @(negedge clk);  // DONE: one cycle after the handshake
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL store_release: got %0b want 0", stall_out); end
    n_checks++; if (dmem.req_valid !== 1'b0) begin n_fail++; $display("FAIL store_done_valid: got %0b want 0", dmem.req_valid); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if ({wb_reg_write, wb_alu_result, wb_mem_data, wb_data} !== {1'b0, 32'h200, 32'h0, 32'h200}) begin n_fail++; $display("FAIL store_wb: rw=%0b alu=%h mem=%h data=%h want 0 00000200 0 00000200", wb_reg_write, wb_alu_result, wb_mem_data, wb_data); end
    tick();
  endtask

  task automatic test_misaligned();
    reg_write_in = 1'b1; reg_addr_i_in = 5'd4; alu_result_in = 32'h77;
    tick();  // plain instruction so MEM/WB holds reg_write=1 beforehand
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; alu_result_in = 32'h102;
    dmem.req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL mis_prior_wb: got %0b want 1", wb_reg_write); end
    n_checks++; if ({stall_out, dmem.req_valid} !== 2'b00) begin n_fail++; $display("FAIL mis_no_stall_req: stall=%0b valid=%0b want 0 0", stall_out, dmem.req_valid); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL mis_align_err: got %0b want 1", align_err); end
    n_checks++; if ({wb_reg_write, wb_data} !== 33'd0) begin n_fail++; $display("FAIL mis_bubble: rw=%0b data=%h want 0 0", wb_reg_write, wb_data); end
    n_checks++; if ({stall_out, dmem.req_valid} !== 2'b00) begin n_fail++; $display("FAIL mis_after: stall=%0b valid=%0b want 0 0", stall_out, dmem.req_valid); end
    tick();
    @(negedge clk);
    n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width: got %0b want 0", align_err); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
    reg_addr_i_in = 5'd12; alu_result_in = 32'h300;
    dmem.req_ready = 1'b1;
    tick();  // -> REQ
    tick();  // -> WAIT
    @(negedge clk);
    n_checks++; if ({stall_out, dmem.req_valid} !== 2'b10) begin n_fail++; $display("FAIL rstwait_pre: stall=%0b valid=%0b want 1 0", stall_out, dmem.req_valid); end
    rst = 1'b1;
    clear_inputs();
    #1;
    n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr, dmem.wdata, stall_out} !== 67'd0) begin n_fail++; $display("FAIL rstwait_dmem: valid=%0b we=%0b addr=%h wdata=%h stall=%0b want all 0", dmem.req_valid, dmem.we, dmem.addr, dmem.wdata, stall_out); end
    n_checks++; if ({wb_reg_write, wb_mem_to_reg, wb_reg_addr, wb_alu_result, wb_mem_data, wb_data, align_err} !== 104'd0) begin n_fail++; $display("FAIL rstwait_wb: rw=%0b m2r=%0b ra=%0d alu=%h mem=%h data=%h want all 0", wb_reg_write, wb_mem_to_reg, wb_reg_addr, wb_alu_result, wb_mem_data, wb_data); end
    tick();
    rst = 1'b0;
    dmem.rsp_valid = 1'b1; dmem.rsp_rdata = 32'h55AA55AA;
    tick();
    dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
    @(negedge clk);
    n_checks++; if ({wb_reg_write, wb_mem_data, wb_data} !== 65'd0) begin n_fail++; $display("FAIL rstwait_ignored: rw=%0b mem=%h data=%h want 0 0 0", wb_reg_write, wb_mem_data, wb_data); end
    n_checks++; if ({stall_out, dmem.req_valid} !== 2'b00) begin n_fail++; $display("FAIL rstwait_idle: stall=%0b valid=%0b want 0 0", stall_out, dmem.req_valid); end
    // A plain instruction must now complete in one cycle, proving the FSM is idle.
    reg_write_in = 1'b1; reg_addr_i_in = 5'd6; alu_result_in = 32'h9;
    @(negedge clk);
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL rstwait_next_stall: got %0b want 0", stall_out); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if ({wb_reg_write, wb_reg_addr, wb_data} !== {1'b1, 5'd6, 32'h9}) begin n_fail++; $display("FAIL rstwait_next_wb: rw=%0b ra=%0d data=%h want 1 6 00000009", wb_reg_write, wb_reg_addr, wb_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
    reg_dst_in = 1'b1; reg_addr_r_in = 5'd3; alu_result_in = 32'h40;
    dmem.req_ready = 1'b1;
    tick();  // -> REQ
    @(negedge clk);
    n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr} !== {1'b1, 1'b0, 32'h40}) begin n_fail++; $display("FAIL b2b_load_req: valid=%0b we=%0b addr=%h want 1 0 00000040", dmem.req_valid, dmem.we, dmem.addr); end
    tick();  // -> WAIT
    dmem.rsp_valid = 1'b1; dmem.rsp_rdata = 32'h11112222;
    tick();  // -> DONE
    dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
    tick();  // DONE edge: upstream advances to the store
    mem_read_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
    mem_write_in = 1'b1; alu_result_in = 32'h44; rt_in = 32'hAAAA5555;
    @(negedge clk);
    n_checks++; if ({wb_reg_write, wb_reg_addr, wb_data} !== {1'b1, 5'd3, 32'h11112222}) begin n_fail++; $display("FAIL b2b_load_wb: rw=%0b ra=%0d data=%h want 1 3 11112222", wb_reg_write, wb_reg_addr, wb_data); end
    n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL b2b_store_stall: got %0b want 1", stall_out); end
    tick();  // -> REQ
    @(negedge clk);
    n_checks++; if ({dmem.req_valid, dmem.we, dmem.addr, dmem.wdata} !== {1'b1, 1'b1, 32'h44, 32'hAAAA5555}) begin n_fail++; $display("FAIL b2b_store_req: valid=%0b we=%0b addr=%h wdata=%h want 1 1 00000044 aaaa5555", dmem.req_valid, dmem.we, dmem.addr, dmem.wdata); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %0b want 0", wb_reg_write); end
    tick();  // -> DONE
    @(negedge clk);
    n_checks++; if ({stall_out, dmem.req_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_store_done: stall=%0b valid=%0b want 0 0", stall_out, dmem.req_valid); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if ({wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_mem_data, wb_data} !== {1'b0, 1'b0, 32'h44, 32'h0, 32'h44}) begin n_fail++; $display("FAIL b2b_final_wb: rw=%0b m2r=%0b alu=%h mem=%h data=%h want 0 0 00000044 0 00000044", wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_mem_data, wb_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load();
    test_store_backpressure();
    test_misaligned();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
